enigma_key_stepper: RTL

//  Front stage of the Enigma datapath, directly upstream of the rotor stage. Accepts one key (letter 0..25)
//  per transaction, applies the programmable plugboard swap and advances the two rotor positions.

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/enigma_plugboard.sv | 50 +++++
 rtl/enigma_key_stepper.sv | 106 ++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared types, constants and mod-26 helpers for the Enigma front stage.
package enigma_pkg;

  localparam int ALPHA = 26;

  typedef logic [4:0] letter_t;

  localparam letter_t LAST       = 5'd25;
  localparam letter_t NOTCH1_DEF = 5'd16;
  localparam letter_t NOTCH2_DEF = 5'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Advance one position with the 25 -> 0 wrap.
  function automatic letter_t inc26(input letter_t v);
    return (v >= LAST) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic letter_t clamp26(input letter_t v);
    return (v > LAST) ? LAST : v;
  endfunction

endpackage

// File: rtl/enigma_plugboard.sv
// Plugboard: 26-entry involution table with a symmetric pair-write port and
// a combinational lookup.
module enigma_plugboard
  import enigma_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we_i,
  input  letter_t a_i,
  input  letter_t b_i,
  input  letter_t idx_i,
  output letter_t val_o
);

  letter_t tab [ALPHA];
  letter_t part_a;
  letter_t part_b;
  logic    wr_ok;

  assign wr_ok  = we_i && (a_i <= LAST) && (b_i <= LAST);
  assign part_a = tab[clamp26(a_i)];
  assign part_b = tab[clamp26(b_i)];
  assign val_o  = (idx_i > LAST) ? LAST : tab[idx_i];

  for (genvar gi = 0; gi < ALPHA; gi++) begin : g_ent
    letter_t ent_q;
    letter_t ent_d;

    // New pair wins over the old partners reverting to themselves.
    always_comb begin
      ent_d = ent_q;
      if (wr_ok) begin
        if (letter_t'(gi) == a_i)
          ent_d = b_i;
        else if (letter_t'(gi) == b_i)
          ent_d = a_i;
        else if (letter_t'(gi) == part_a || letter_t'(gi) == part_b)
          ent_d = letter_t'(gi);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ent_q <= letter_t'(gi);
      else        ent_q <= ent_d;
    end

    assign tab[gi] = ent_q;
  end

endmodule

// File: rtl/enigma_key_stepper.sv
// Enigma front stage: plugboard swap plus rotor-1/rotor-2 stepping FSM.
// Define ENIGMA_DOUBLE_STEP_EN to enable the rotor-2 double-step anomaly.
module enigma_key_stepper
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = NOTCH1_DEF,
  parameter letter_t NOTCH2 = NOTCH2_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       in_ready,
  input  logic       cfg_we,
  input  logic [4:0] cfg_a,
  input  logic [4:0] cfg_b,
  input  logic       pos_load,
  input  logic [4:0] pos1_init,
  input  logic [4:0] pos2_init,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_letter,
  output logic [4:0] out_pos1,
  output logic [4:0] out_pos2,
  output logic       out_err
);

`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  state_t  state_q;
  letter_t letter_q;
  letter_t pos1_q;
  letter_t pos2_q;
  logic    err_q;
  logic    valid_q;
  letter_t plug_val;
  logic    plug_we;
  logic    key_bad;
  logic    carry;

  assign in_ready = (state_q == IDLE) && !pos_load && !cfg_we;
  assign plug_we  = (state_q == IDLE) && cfg_we && !pos_load;
  assign key_bad  = in_letter > LAST;
  // Either condition steps rotor 2 exactly once.
  assign carry    = (pos1_q == NOTCH1) || (DBL_EN && (pos2_q == NOTCH2));

  enigma_plugboard u_plug (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (plug_we),
    .a_i   (cfg_a),
    .b_i   (cfg_b),
    .idx_i (in_letter),
    .val_o (plug_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      letter_q <= '0;
      pos1_q   <= '0;
      pos2_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pos_load) begin
            pos1_q <= clamp26(pos1_init);
            pos2_q <= clamp26(pos2_init);
          end else if (!cfg_we && in_valid) begin
            letter_q <= key_bad ? LAST : plug_val;
            err_q    <= key_bad;
            state_q  <= STEP;
          end
        end
        STEP: begin
          if (!err_q) begin
            pos1_q <= inc26(pos1_q);
            if (carry) pos2_q <= inc26(pos2_q);
          end
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_letter = letter_q;
  assign out_pos1   = pos1_q;
  assign out_pos2   = pos2_q;
  assign out_err    = err_q;

endmodule
